// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : IF-stage instruction fetch queue. Buffers {pc, instr} pairs in
//             a circular buffer and presents them in order to decode with a
//             valid/ready handshake. Shows a NOP bubble when empty and is
//             cleared by a branch/jump flush.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int          DEPTH = 4,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic                     clock,
    input  logic                     reset,      // asynchronous, active-low
    input  logic                     flush,
    input  logic                     enq_valid,
    input  logic [31:0]              enq_pc,
    input  logic [31:0]              enq_instr,
    output logic                     enq_ready,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [31:0]              deq_pc,
    output logic [31:0]              deq_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    // Entry layout: pc in the upper word, instruction in the lower word.
    logic [63:0]     r_mem [0:DEPTH-1];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_enq_fire;
    logic w_deq_fire;

    // Handshake qualifiers; flush overrides both sides of the queue.
    always_comb begin
        w_full     = (r_count == c_FULL);
        w_empty    = (r_count == '0);
        w_enq_fire = enq_valid & ~w_full  & ~flush;
        w_deq_fire = deq_ready & ~w_empty & ~flush;
    end

    // Entry storage: contents are never cleared, occupancy decides validity.
    always_ff @(posedge clock) begin
        if (w_enq_fire) begin
            r_mem[r_wr_ptr] <= {enq_pc, enq_instr};
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq_fire) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_deq_fire) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_enq_fire, w_deq_fire})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Outputs derive only from registered state; an empty queue shows a bubble.
    always_comb begin
        enq_ready = ~w_full;
        deq_valid = ~w_empty;
        count     = r_count;
        deq_pc    = 32'h0;
        deq_instr = NOP;
        if (!w_empty) begin
            deq_pc    = r_mem[r_rd_ptr][63:32];
            deq_instr = r_mem[r_rd_ptr][31:0];
        end
    end

endmodule
`default_nettype wire
